// File: rtl/controladora_entradas.sv
// -----------------------------------------------------------------------------
// controladora_entradas
//
// Input front-end for the lighting controller FSM. It turns a bouncy raw
// push-button, a raw presence sensor and the controller's own `enable` output
// into the controller's command inputs.
//
// Ports:
//   clk       in   clock, every flop on the rising edge
//   rst       in   asynchronous active-high reset
//   btn_i     in   raw push-button, active-high, bouncy
//   sensor_i  in   raw presence sensor, active-high
//   enable    in   from the controller; arms the inactivity timer
//   a         out  one-cycle pulse: long press (mode toggle)
//   b         out  one-cycle pulse: short press (manual toggle)
//   c         out  one-cycle pulse: inactivity timeout
//   d         out  registered presence level
//
// Build option:
//   CONTROLADORA_ENTRADAS_SYNC_EN  when defined, btn_i and sensor_i each pass
//   through a 2-flop synchronizer ahead of the sampling register, making the
//   input-to-sample latency 3 cycles instead of 1. Everything downstream of
//   the sampling register is identical in both builds.
// -----------------------------------------------------------------------------
module controladora_entradas #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int LONG_CYC     = 1000,
    parameter int TIMEOUT_CYC  = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic sensor_i,
    input  logic enable,
    output logic a,
    output logic b,
    output logic c,
    output logic d
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESSED   = 2'b01,
        LONG_HELD = 2'b10
    } press_state_t;

    logic               btn_pre_s;
    logic               sensor_pre_s;
    logic               btn_s;
    logic               sensor_s;
    logic               btn_db_r;
    logic [DB_W-1:0]    db_cnt_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [TO_W-1:0]    to_cnt_r;
    press_state_t       state_r;

`ifdef CONTROLADORA_ENTRADAS_SYNC_EN
    logic [1:0] btn_sync_r;
    logic [1:0] sensor_sync_r;

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync_r    <= 2'b00;
            sensor_sync_r <= 2'b00;
        end else begin
            btn_sync_r    <= {btn_sync_r[0], btn_i};
            sensor_sync_r <= {sensor_sync_r[0], sensor_i};
        end
    end

    assign btn_pre_s    = btn_sync_r[1];
    assign sensor_pre_s = sensor_sync_r[1];
`else
    assign btn_pre_s    = btn_i;
    assign sensor_pre_s = sensor_i;
`endif

    // Sampling register: the single point every downstream count refers to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s    <= 1'b0;
            sensor_s <= 1'b0;
        end else begin
            btn_s    <= btn_pre_s;
            sensor_s <= sensor_pre_s;
        end
    end

    // Debounce: the level must disagree for DEBOUNCE_CYC consecutive cycles
    // before it is accepted; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db_r <= 1'b0;
            db_cnt_r <= {DB_W{1'b0}};
        end else if (btn_s != btn_db_r) begin
            if (db_cnt_r == DB_LAST) begin
                btn_db_r <= btn_s;
                db_cnt_r <= {DB_W{1'b0}};
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end else begin
            db_cnt_r <= {DB_W{1'b0}};
        end
    end

    // Press classifier: each press yields exactly one of a (long) or b (short)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            hold_cnt_r <= {HOLD_W{1'b0}};
            a          <= 1'b0;
            b          <= 1'b0;
        end else begin
            a <= 1'b0;
            b <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (btn_db_r) begin
                        state_r    <= PRESSED;
                        hold_cnt_r <= {HOLD_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRESSED: begin
                    if (!btn_db_r) begin
                        state_r <= IDLE;
                        b       <= 1'b1;
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        // The long pulse is issued once on entry; LONG_HELD
                        // then just waits for release.
                        state_r <= LONG_HELD;
                        a       <= 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                LONG_HELD: begin
                    if (!btn_db_r) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= LONG_HELD;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    hold_cnt_r <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    // Presence level straight from the sampled sensor; it is level-stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= 1'b0;
        end else begin
            d <= sensor_s;
        end
    end

    // Inactivity timer: presence or a disarmed controller takes priority over
    // expiry, so neither can coincide with a c pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {TO_W{1'b0}};
            c        <= 1'b0;
        end else begin
            c <= 1'b0;
            if (!enable || sensor_s) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else if (to_cnt_r == TO_LAST) begin
                to_cnt_r <= {TO_W{1'b0}};
                c        <= 1'b1;
            end else begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_controladora_entradas.sv
// -----------------------------------------------------------------------------
// tb_controladora_entradas
//
// Directed bench for controladora_entradas with DEBOUNCE_CYC=4, LONG_CYC=20,
// TIMEOUT_CYC=50 and the synchronizer option off. Inputs are changed 1 ns
// after a rising edge, so a change made after edge N is sampled at edge N+1.
// `cyc` numbers the rising edges; every cycle in which a, b, c or d is high
// is logged with its edge number, so a one-cycle pulse appears exactly once.
// Expected edge numbers below are derived from the block's transfer rules:
//   btn_i change after edge s -> btn_s at s+1 -> debounced level at s+5
//   debounced rise at p -> PRESSED at p+1 -> hold count 19 at p+20 -> a at p+21
//   debounced fall at f while PRESSED -> b at f+1
//   enable raised after edge s -> timer 1 at s+1 -> c at s+50, s+100, ...
// -----------------------------------------------------------------------------
module tb_controladora_entradas;

    logic clk = 1'b0;
    logic rst;
    logic btn_i;
    logic sensor_i;
    logic enable;
    logic a;
    logic b;
    logic c;
    logic d;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int db_hi = 0;
    int a_q[$];
    int b_q[$];
    int c_q[$];
    int d_q[$];
    int s;

    controladora_entradas #(
        .DEBOUNCE_CYC(4),
        .LONG_CYC    (20),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_i),
        .sensor_i(sensor_i),
        .enable  (enable),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and log which outputs are high after it
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (a) a_q.push_back(cyc);
        if (b) b_q.push_back(cyc);
        if (c) c_q.push_back(cyc);
        if (d) d_q.push_back(cyc);
        if (dut.btn_db_r) db_hi++;
    endtask

    task automatic clear_logs();
        a_q.delete();
        b_q.delete();
        c_q.delete();
        d_q.delete();
        db_hi = 0;
    endtask

    initial begin
        rst      = 1'b1;
        btn_i    = 1'b0;
        sensor_i = 1'b1;
        enable   = 1'b0;
        repeat (3) tick();
        check("reset_outs", int'({a, b, c, d}), 0);

        sensor_i = 1'b0;
        rst      = 1'b0;
        repeat (5) tick();

        // 1. Bounce rejection: a 1-cycle glitch never survives debounce
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            btn_i = (i % 2 == 0);
            tick();
        end
        btn_i = 1'b0;
        repeat (10) tick();
        check("bounce_a", a_q.size(), 0);
        check("bounce_b", b_q.size(), 0);
        check("bounce_db", db_hi, 0);

        // 2. Short press: release sampled at s+11, debounced fall s+15, b at s+16
        clear_logs();
        s = cyc;
        btn_i = 1'b1;
        repeat (10) tick();
        btn_i = 1'b0;
        repeat (15) tick();
        check("short_b_count", b_q.size(), 1);
        check("short_b_edge", (b_q.size() > 0) ? b_q[0] : -1, s + 16);
        check("short_a_count", a_q.size(), 0);

        // 3. Long press: debounced rise s+5, a at s+26; release gives nothing
        clear_logs();
        s = cyc;
        btn_i = 1'b1;
        repeat (100) tick();
        btn_i = 1'b0;
        repeat (20) tick();
        check("long_a_count", a_q.size(), 1);
        check("long_a_edge", (a_q.size() > 0) ? a_q[0] : -1, s + 26);
        check("long_b_count", b_q.size(), 0);

        // 4. Timeout re-fires every 50 cycles while armed with no presence
        clear_logs();
        s = cyc;
        enable = 1'b1;
        repeat (120) tick();
        enable = 1'b0;
        tick();
        check("to_c_count", c_q.size(), 2);
        check("to_c_first", (c_q.size() > 0) ? c_q[0] : -1, s + 50);
        check("to_c_second", (c_q.size() > 1) ? c_q[1] : -1, s + 100);

        // 5. Presence at timer count 49 cancels expiry and restarts the count
        tick();
        clear_logs();
        s = cyc;
        enable = 1'b1;
        repeat (48) tick();
        sensor_i = 1'b1;
        tick();
        sensor_i = 1'b0;
        repeat (61) tick();
        enable = 1'b0;
        tick();
        check("pres_c_count", c_q.size(), 1);
        check("pres_c_edge", (c_q.size() > 0) ? c_q[0] : -1, s + 100);
        check("pres_d_count", d_q.size(), 1);
        check("pres_d_edge", (d_q.size() > 0) ? d_q[0] : -1, s + 50);

        // 6. Reset at hold count 15 (edge s+21); the held button is a new press
        clear_logs();
        s = cyc;
        btn_i    = 1'b1;
        sensor_i = 1'b1;
        repeat (21) tick();
        rst = 1'b1;
        #1;
        check("rst_mid_outs", int'({a, b, c, d}), 0);
        clear_logs();
        repeat (3) tick();
        check("rst_held_outs", int'({a, b, c, d}), 0);
        rst      = 1'b0;
        sensor_i = 1'b0;
        // btn_s at s+25, debounced s+29, PRESSED s+30, a at s+50
        repeat (40) tick();
        btn_i = 1'b0;
        repeat (15) tick();
        check("rst_a_count", a_q.size(), 1);
        check("rst_a_edge", (a_q.size() > 0) ? a_q[0] : -1, s + 50);
        check("rst_b_count", b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
